// File: rtl/spi_block_top_if.sv
// SPI pin and host command/status bundle for spi_block_top.
// The slave side belongs to the block; the master side drives the pins and the host strobe.
interface spi_block_top_if;
  logic        ss;
  logic        sclk;
  logic        mosi;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        full_alarm_led;
  logic        empty_alarm_led;

  modport master (
    output ss, sclk, mosi, wr, data_in,
    input  data_out, full_alarm_led, empty_alarm_led
  );

  modport slave (
    input  ss, sclk, mosi, wr, data_in,
    output data_out, full_alarm_led, empty_alarm_led
  );
endinterface

// File: rtl/spi_block_top.sv
// SPI mode-0 slave receiver into a 2^DEPTH_LOG2 byte FIFO with host pop/flush; SPI_INPUT_SYNC_EN adds 2-flop input sync.
// Push lands 3 clk after a sclk pin rise (4 with sync), commands 2 clk after wr; no backpressure, bytes are dropped when full.
module spi_block_top #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic            clk,
  input  logic            rst,
  spi_block_top_if.slave  bus
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Pin vector order: {wr, mosi, sclk, ss}; ss resets high so we start deselected.
  localparam logic [3:0] PIN_RST = 4'b0001;

  logic [3:0] pins;
  logic [3:0] in1_q, in1_d;
  logic [3:0] in_s;

  assign pins = {bus.wr, bus.mosi, bus.sclk, bus.ss};

  always_comb begin
    in1_d = pins;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in1_q <= PIN_RST;
    else      in1_q <= in1_d;
  end

`ifdef SPI_INPUT_SYNC_EN
  logic [3:0] in2_q, in2_d;

  always_comb begin
    in2_d = in1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in2_q <= PIN_RST;
    else      in2_q <= in2_d;
  end

  assign in_s = in2_q;
`else
  assign in_s = in1_q;
`endif

  logic ss_s, sclk_s, mosi_s, wr_s;
  assign {wr_s, mosi_s, sclk_s, ss_s} = in_s;

  logic sclk_prev_q, sclk_prev_d;
  logic wr_prev_q, wr_prev_d;
  logic sclk_rise, wr_rise;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign wr_rise   = wr_s & ~wr_prev_q;

  // Byte assembly: the completed byte is staged one cycle before it hits the FIFO.
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       push_vld_q, push_vld_d;
  logic [7:0] push_dat_q, push_dat_d;

  always_comb begin
    sclk_prev_d = sclk_s;
    wr_prev_d   = wr_s;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    push_vld_d  = 1'b0;
    push_dat_d  = push_dat_q;
    if (ss_s) begin
      shift_d  = 8'h00;
      bitcnt_d = 3'd0;
    end else if (sclk_rise) begin
      shift_d  = {shift_q[6:0], mosi_s};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        push_vld_d = 1'b1;
        push_dat_d = {shift_q[6:0], mosi_s};
      end
    end
  end

  // FIFO and host command execution.
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       rd_q, rd_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_flush, do_pop, do_push;

  assign do_flush = wr_rise & bus.data_in[31];
  assign do_pop   = wr_rise & ~bus.data_in[31] & bus.data_in[0] & (count_q != '0);
  assign do_push  = push_vld_q & (count_q != FULL_CNT) & ~do_flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rd_d    = rd_q;
    if (do_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop) begin
        rptr_d = rptr_q + PTR_W'(1);
        rd_d   = mem[rptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_dat_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_prev_q <= 1'b0;
      wr_prev_q   <= 1'b0;
      shift_q     <= 8'h00;
      bitcnt_q    <= 3'd0;
      push_vld_q  <= 1'b0;
      push_dat_q  <= 8'h00;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_q        <= 8'h00;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      wr_prev_q   <= wr_prev_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      push_vld_q  <= push_vld_d;
      push_dat_q  <= push_dat_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  logic [9:0] cnt_field;
  logic       unused_cmd_bits;

  assign cnt_field       = 10'(count_q);
  assign unused_cmd_bits = ^bus.data_in[30:1];

  assign bus.data_out        = {empty_q, full_q, 12'h000, cnt_field, rd_q};
  assign bus.full_alarm_led  = full_q;
  assign bus.empty_alarm_led = empty_q;

endmodule

// File: tb/tb_spi_block_top.sv
// Randomized bench for spi_block_top against a queue-based FIFO model.
module tb_spi_block_top;

  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_block_top_if bus_if ();

  spi_block_top #(.DEPTH_LOG2(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq [$];
  logic [7:0] rd_m;

  // Expected {full_led, empty_led, data_out} from the model.
  function automatic logic [33:0] exp_vec();
    int   n;
    logic e, f;
    n = mq.size();
    e = (n == 0);
    f = (n == DEPTH);
    return {f, e, e, f, 12'h000, 10'(n), rd_m};
  endfunction

  function automatic logic [33:0] obs_vec();
    return {bus_if.full_alarm_led, bus_if.empty_alarm_led, bus_if.data_out};
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
  endtask

  task automatic model_cmd(input logic [31:0] d);
    if (d[31]) mq.delete();
    else if (d[0] && mq.size() > 0) rd_m = mq.pop_front();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ss(input logic v);
    bus_if.ss = v;
    wait_clk(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.mosi = b[7-i];
      wait_clk(4);
      bus_if.sclk = 1'b1;
      wait_clk(4);
      bus_if.sclk = 1'b0;
    end
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    model_push(b);
  endtask

  task automatic cmd(input logic [31:0] d, input int len);
    bus_if.data_in = d;
    bus_if.wr      = 1'b1;
    wait_clk(len);
    bus_if.wr = 1'b0;
    wait_clk(4);
    bus_if.data_in = 32'h0;
    model_cmd(d);
  endtask

  task automatic test_reset();
    checks++;
    if (obs_vec() !== {1'b0, 1'b1, 32'h8000_0000}) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", obs_vec(), {1'b0, 1'b1, 32'h8000_0000});
    end
    rst = 1'b1;
    wait_clk(3);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_byte();
    set_ss(1'b0);
    send_byte(8'h1F);
    set_ss(1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || bus_if.data_out[17:8] !== 10'd1) begin
      failures++;
      $display("FAIL single_push got=%h exp=%h", obs_vec(), exp_vec());
    end
    cmd(32'h1, 1);
    checks++;
    if (bus_if.data_out !== 32'h8000_001F || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL single_pop got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    set_ss(1'b0);
    send_byte(8'h1F);
    send_byte(8'hF3);
    set_ss(1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || bus_if.data_out[17:8] !== 10'd2) begin
      failures++;
      $display("FAIL b2b_count got=%h exp=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      cmd(32'h1, 2);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_pop%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_commands();
    set_ss(1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    set_ss(1'b1);
    cmd(32'h0, 1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL cmd_nop got=%h exp=%h", obs_vec(), exp_vec());
    end
    cmd(32'h0000_0001, 12);
    checks++;
    if (obs_vec() !== exp_vec() || bus_if.data_out[17:8] !== 10'd2) begin
      failures++;
      $display("FAIL cmd_long_pulse got=%h exp=%h", obs_vec(), exp_vec());
    end
    // Bit 31 outranks bit 0 even when both are set.
    cmd(32'h8000_0001, 1);
    checks++;
    if (obs_vec() !== exp_vec() || bus_if.empty_alarm_led !== 1'b1) begin
      failures++;
      $display("FAIL cmd_flush got=%h exp=%h", obs_vec(), exp_vec());
    end
    cmd(32'h8000_0000, 3);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL cmd_flush2 got=%h exp=%h", obs_vec(), exp_vec());
    end
    cmd(32'h1, 1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL cmd_pop_empty got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_partial();
    set_ss(1'b0);
    send_bits(8'hA5, 5);
    set_ss(1'b1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL partial_nopush got=%h exp=%h", obs_vec(), exp_vec());
    end
    set_ss(1'b0);
    send_byte(8'h6C);
    set_ss(1'b1);
    cmd(32'h1, 1);
    checks++;
    if (obs_vec() !== exp_vec() || bus_if.data_out[7:0] !== 8'h6C) begin
      failures++;
      $display("FAIL partial_next got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    cmd(32'h8000_0000, 1);
    set_ss(1'b0);
    for (int i = 1; i <= 520; i++) begin
      send_byte(8'hF3);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL overflow_byte%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    set_ss(1'b1);
    checks++;
    if (bus_if.full_alarm_led !== 1'b1 || bus_if.data_out[17:8] !== 10'd512) begin
      failures++;
      $display("FAIL overflow_sat got=%h exp_count=512 full=1", obs_vec());
    end
    cmd(32'h1, 1);
    checks++;
    if (obs_vec() !== exp_vec() || bus_if.data_out[17:8] !== 10'd511) begin
      failures++;
      $display("FAIL overflow_pop got=%h exp=%h", obs_vec(), exp_vec());
    end
    cmd(32'h8000_0000, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        set_ss(1'b0);
        send_byte(8'($urandom));
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
        set_ss(1'b1);
      end else if (r <= 7) begin
        cmd(32'h1 | ($urandom & 32'h7FFF_FFFE), $urandom_range(1, 6));
      end else if (r == 8) begin
        set_ss(1'b0);
        send_bits(8'($urandom), $urandom_range(1, 7));
        set_ss(1'b1);
      end else begin
        cmd(($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0, 1);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_op%0d kind=%0d got=%h exp=%h", it, r, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    set_ss(1'b0);
    send_byte(8'h3C);
    send_bits(8'hFF, 3);
    rst = 1'b0;
    mq.delete();
    rd_m = 8'h00;
    wait_clk(2);
    checks++;
    if (obs_vec() !== {1'b0, 1'b1, 32'h8000_0000}) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", obs_vec(), {1'b0, 1'b1, 32'h8000_0000});
    end
    bus_if.ss = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(2);
    set_ss(1'b0);
    send_byte(8'hC5);
    set_ss(1'b1);
    cmd(32'h1, 1);
    checks++;
    if (obs_vec() !== exp_vec() || bus_if.data_out[7:0] !== 8'hC5) begin
      failures++;
      $display("FAIL reset_recover got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus_if.ss      = 1'b1;
    bus_if.sclk    = 1'b0;
    bus_if.mosi    = 1'b0;
    bus_if.wr      = 1'b0;
    bus_if.data_in = 32'h0;
    rd_m           = 8'h00;
    wait_clk(3);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_commands();
    test_partial();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_block_top.md
# spi_block_top

SPI slave receive block with a byte FIFO and a 32-bit host command/status port. It oversamples SS/SCLK/MOSI in the system clock domain and assembles MSB-first bytes. Completed bytes are pushed into an on-chip FIFO. The host pops or flushes the FIFO via `wr`/`data_in` and reads the last byte, fill count and flags on `data_out`. It sits between an external SPI master and the local controller; two LEDs show the FIFO full and empty alarms.

## Interface
- `DEPTH_LOG2`, default 9: FIFO depth is 2^DEPTH_LOG2 bytes (512).
- `clk`  in  1  system clock; all logic rises on it. SPI pins are asynchronous to it.
- `rst`  in  1  asynchronous, active-low reset.
- `ss`  in  1  SPI slave select, active low.
- `sclk`  in  1  SPI clock, mode 0; data is sampled on its rising edge.
- `mosi`  in  1  SPI serial data in, MSB first.
- `wr`  in  1  host command strobe; acts on its 0→1 edge.
- `data_in`  in  32  host command word.
- `data_out`  out  32  status/read word.
- `full_alarm_led`  out  1  high while FIFO count == 2^DEPTH_LOG2.
- `empty_alarm_led`  out  1  high while FIFO count == 0.

## Operation
- **Input path:** `ss`, `sclk`, `mosi` are registered on `clk`. `sclk` rise = registered sclk is 1 and its previous sample was 0.
- **Shifting:** on a sclk rise while `ss`=0, shift `mosi` into an 8-bit shift register (MSB first) and increment a 3-bit bit counter.
- **Byte complete:** the 8th rise completes the byte and pushes it into the FIFO; the counter wraps to 0. `ss` may stay low across consecutive bytes.
- **SS high:** `ss`=1 clears the bit counter, discards any partial byte and ignores `sclk`.
- **FIFO:** 2^DEPTH_LOG2 × 8 bits, circular read/write pointers, count width DEPTH_LOG2+1.
- **Push when full:** the byte is dropped and pointers are unchanged.
- **Commands:** `wr` is registered and edge-detected, and a command executes once per 0→1 edge. A long `wr` pulse is one command, and a 1-cycle pulse is valid.
  - `data_in[31]`=1: flush. Pointers and count go to 0; the read byte is unchanged.
  - else `data_in[0]`=1: pop. The head byte is loaded into the read-byte register and the count decrements.
  - otherwise: no operation.
- **Pop when empty:** no-op; the read byte is unchanged.
- **`data_out` layout:**
  - [7:0] last popped byte
  - [17:8] FIFO count
  - [29:18] 0
  - [30] full
  - [31] empty
- **Simultaneous push and pop:** both happen and the count is unchanged.
- **Simultaneous push and flush:** flush wins and the byte is lost.
- **Reset values:** shift register, bit counter, pointers, count and read byte all 0. `data_out`=0x8000_0000, `empty_alarm_led`=1, `full_alarm_led`=0.
- **Reset mid-byte:** the partial byte is lost.

## Timing
- Input registering is 1 stage, or 2 with SPI_INPUT_SYNC_EN.
- Edge detect takes 1 further cycle.
- Push latency: the FIFO count updates 1 clk after the detected 8th sclk rise. That is at most 3 clk (4 with sync) after the `sclk` pin rises.
- Command latency: `data_out` and the LEDs update 2 clk after the `wr` pin rises.
- LEDs and `data_out[31:30]` are registered and consistent with `data_out[17:8]` in the same cycle.
- Minimum sclk high and low time: 3 clk periods (4 with sync).

## Configuration
- Macro `SPI_INPUT_SYNC_EN`.
- Defined: `ss`, `sclk`, `mosi` and `wr` each pass through a 2-flop synchronizer before edge detection, giving +1 cycle latency.
- Undefined: a single register stage, for use when the SPI pins are already synchronous to `clk`.

## Test plan
- **Reset:** assert `rst`=0 mid-operation → `data_out`=0x8000_0000, empty LED=1, full LED=0.
- **Single byte:** `ss`=0, 8 sclk pulses with mosi 0,0,0,1,1,1,1,1 → count=1, empty LED=0. Then pulse `wr` with `data_in`=0x1 → `data_out`=0x8000_001F, empty LED=1.
- **Back-to-back bytes:** without raising `ss`, send 0x1F then 0xF3, then pop twice → `data_out[7:0]`=0x1F then 0xF3. Check `data_out[17:8]` reads 2, then 1, then 0.
- **Overflow:** 520 bytes of 0xF3 → count saturates at 512, full LED=1 from byte 512 on, extra bytes dropped. One pop → full LED=0, count=511.
- **Commands:** `wr` with `data_in`=0x0 → no change. `wr` with 0x8000_0000 → count=0, empty LED=1. A second flush is harmless. A 12-cycle `wr` pulse pops only once.
- **Partial byte:** `ss` raised after 5 bits → no push. Next full byte is received correctly.
